// File: rtl/leaves_mem_loader.sv
// Collects LEAF_SIZE patches into a leaf buffer and writes each full leaf to a single-port memory.
// Define LEAVES_MEM_LOADER_READBACK_EN to read back and verify every leaf after it is written.
module leaves_mem_loader #(
  parameter int DATA_WIDTH = 11,
  parameter int LEAF_SIZE  = 8,
  parameter int PATCH_SIZE = 5,
  parameter int NUM_LEAVES = 64,
  parameter int ADDR_WIDTH = $clog2(NUM_LEAVES)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] in_patch,
  output logic                                  csb0,
  output logic                                  web0,
  output logic [ADDR_WIDTH-1:0]                 addr0,
  output logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] wleaf0 [LEAF_SIZE],
  input  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] rleaf0 [LEAF_SIZE],
  output logic                                  busy,
  output logic                                  done,
  output logic [ADDR_WIDTH-1:0]                 leaf_idx,
  output logic                                  rb_error
);

  localparam int CNT_W = (LEAF_SIZE > 1) ? $clog2(LEAF_SIZE) : 1;

  typedef logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] patch_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_RDREQ,
    S_RDCHK,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] patch_cnt;
  patch_t           leaf_buf [LEAF_SIZE];
  logic             accept;
  logic             last_patch;
  logic             last_leaf;
  logic             start_pass;
  logic             leaf_done;

  assign accept     = in_valid & in_ready;
  assign last_patch = (patch_cnt == CNT_W'(LEAF_SIZE - 1));
  assign last_leaf  = (leaf_idx == ADDR_WIDTH'(NUM_LEAVES - 1));
  assign start_pass = start & ((state == S_IDLE) | (state == S_DONE));

`ifdef LEAVES_MEM_LOADER_READBACK_EN
  assign leaf_done = (state == S_RDCHK);
`else
  assign leaf_done = (state == S_WRITE);
`endif

  // NOTE: every output and next-state signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    csb0       = 1'b1;
    web0       = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FILL;
      end
      S_FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_patch) state_next = S_WRITE;
      end
      S_WRITE: begin
        busy = 1'b1;
        csb0 = 1'b0;
        web0 = 1'b0;
`ifdef LEAVES_MEM_LOADER_READBACK_EN
        state_next = S_RDREQ;
`else
        state_next = last_leaf ? S_DONE : S_FILL;
`endif
      end
      S_RDREQ: begin
        busy       = 1'b1;
        csb0       = 1'b0;
        state_next = S_RDCHK;
      end
      S_RDCHK: begin
        busy       = 1'b1;
        state_next = last_leaf ? S_DONE : S_FILL;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_FILL;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      patch_cnt <= '0;
      leaf_idx  <= '0;
      addr0     <= '0;
      for (int i = 0; i < LEAF_SIZE; i++) wleaf0[i] <= '0;
    end else begin
      state <= state_next;
      if (start_pass) begin
        patch_cnt <= '0;
        leaf_idx  <= '0;
      end
      if (accept) begin
        patch_cnt <= last_patch ? '0 : patch_cnt + CNT_W'(1);
        // The last patch bypasses the buffer so the write strobe follows one cycle later.
        if (last_patch) begin
          addr0 <= leaf_idx;
          for (int i = 0; i < LEAF_SIZE; i++)
            wleaf0[i] <= (i == LEAF_SIZE - 1) ? in_patch : leaf_buf[i];
        end
      end
      if (leaf_done && !last_leaf) leaf_idx <= leaf_idx + ADDR_WIDTH'(1);
    end
  end

  // NOTE: the leaf buffer is not reset; every slot is written before it is ever read.
  always_ff @(posedge clk) begin
    if (accept) leaf_buf[patch_cnt] <= in_patch;
  end

`ifdef LEAVES_MEM_LOADER_READBACK_EN
  logic rb_mismatch;

  // wleaf0 holds an exact copy of the buffered leaf until the next leaf completes.
  always_comb begin
    rb_mismatch = 1'b0;
    for (int i = 0; i < LEAF_SIZE; i++)
      if (rleaf0[i] != wleaf0[i]) rb_mismatch = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_error <= 1'b0;
    end else if (start_pass) begin
      rb_error <= 1'b0;
    end else if ((state == S_RDCHK) && rb_mismatch) begin
      rb_error <= 1'b1;
    end
  end
`else
  logic rleaf_unused;

  always_comb begin
    rleaf_unused = 1'b0;
    for (int i = 0; i < LEAF_SIZE; i++) rleaf_unused = rleaf_unused ^ (^rleaf0[i]);
  end

  assign rb_error = 1'b0;
`endif

endmodule
